// File: rtl/output_port_fifo_if.sv
// Bus-side bundle for output_port_fifo: CPU push, consumer valid/ready drain,
// display register and status. The master side drives Eout/inputData/outReady/clrOvf.
interface output_port_fifo_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             Eout;
    logic [WIDTH-1:0] inputData;
    logic [WIDTH-1:0] outData;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] outputData;
    logic [CW-1:0]    count;
    logic             full;
    logic             overflow;
    logic             clrOvf;

    modport master (
        output Eout,
        output inputData,
        output outReady,
        output clrOvf,
        input  outData,
        input  outValid,
        input  outputData,
        input  count,
        input  full,
        input  overflow
    );

    modport slave (
        input  Eout,
        input  inputData,
        input  outReady,
        input  clrOvf,
        output outData,
        output outValid,
        output outputData,
        output count,
        output full,
        output overflow
    );
endinterface

// File: rtl/output_port_fifo.sv
// Output port FIFO: buffers CPU OUT writes for a slow valid/ready consumer and keeps
// a display register of the last drained value, occupancy, full and sticky overflow.
module output_port_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    output_port_fifo_if.slave port
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] disp_q, disp_d;
    logic             ovf_q, ovf_d;

    logic empty;
    logic is_full;
    logic pop;
    logic push;
    logic drop;

    assign empty   = (count_q == '0);
    assign is_full = (count_q == CW'(DEPTH));
    assign pop     = ~empty & port.outReady;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push    = port.Eout & (~is_full | pop);
    assign drop    = port.Eout & ~push;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        disp_d   = disp_q;
        ovf_d    = ovf_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            disp_d   = mem[rd_ptr_q];
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Set wins over clear when both happen in the same cycle.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (port.clrOvf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            disp_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            disp_q   <= disp_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr_q] <= port.inputData;
        end
    end

    assign port.outData    = mem[rd_ptr_q];
    assign port.outValid   = ~empty;
    assign port.full       = is_full;
    assign port.count      = count_q;
    assign port.outputData = disp_q;
    assign port.overflow   = ovf_q;

endmodule

// File: tb/tb_output_port_fifo.sv
// Bench for output_port_fifo: a queue-based model checked every cycle on the falling
// edge, plus directed scenarios with hand-computed literal expectations.
module tb_output_port_fifo;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst;

    output_port_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    output_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .port (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a plain queue plus display and overflow values.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_disp;
    logic             m_ovf;
    bit               started = 0;

    always @(posedge clk) begin
        bit do_pop;
        bit do_push;
        started <= 1;
        if (rst) begin
            mq.delete();
            m_disp = '0;
            m_ovf  = 1'b0;
        end else begin
            do_pop  = (mq.size() > 0) && bus.outReady;
            do_push = bus.Eout && ((mq.size() < DEPTH) || do_pop);
            if (do_pop) begin
                m_disp = mq.pop_front();
            end
            if (do_push) begin
                mq.push_back(bus.inputData);
            end
            if (bus.Eout && !do_push) begin
                m_ovf = 1'b1;
            end else if (bus.clrOvf) begin
                m_ovf = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("m_count", 32'(bus.count), 32'(mq.size()));
            check("m_valid", 32'(bus.outValid), 32'(mq.size() != 0));
            check("m_full", 32'(bus.full), 32'(mq.size() == DEPTH));
            check("m_ovf", 32'(bus.overflow), 32'(m_ovf));
            check("m_disp", 32'(bus.outputData), 32'(m_disp));
            if (mq.size() != 0) begin
                check("m_head", 32'(bus.outData), 32'(mq[0]));
            end
        end
    end

    task automatic step(input logic e, input logic [WIDTH-1:0] d, input logic r,
                        input logic c, input logic rs);
        bus.Eout      = e;
        bus.inputData = d;
        bus.outReady  = r;
        bus.clrOvf    = c;
        rst           = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.Eout      = 1'b1;
        bus.inputData = 8'hAA;
        bus.outReady  = 1'b0;
        bus.clrOvf    = 1'b0;
        rst           = 1'b1;

        // Reset with Eout asserted
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_valid", 32'(bus.outValid), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        check("rst_disp", 32'(bus.outputData), 32'h00);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("idle_count", 32'(bus.count), 32'd0);
        check("idle_disp", 32'(bus.outputData), 32'h00);

        // Single transfer
        step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        check("single_valid", 32'(bus.outValid), 32'd1);
        check("single_head", 32'(bus.outData), 32'h3C);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("single_disp", 32'(bus.outputData), 32'h3C);
        check("single_count", 32'(bus.count), 32'd0);
        check("single_valid0", 32'(bus.outValid), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("ready_empty_hold", 32'(bus.outputData), 32'h3C);

        // Fill and overflow
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            if (i == 4) begin
                check("fill_count4", 32'(bus.count), 32'd4);
                check("fill_full", 32'(bus.full), 32'd1);
                check("fill_ovf0", 32'(bus.overflow), 32'd0);
            end
        end
        check("ovf_set", 32'(bus.overflow), 32'd1);
        check("ovf_count", 32'(bus.count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            check("drain_order", 32'(bus.outputData), 32'(i));
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("drain_end_disp", 32'(bus.outputData), 32'h04);
        check("drain_end_valid", 32'(bus.outValid), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("ovf_clr", 32'(bus.overflow), 32'd0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 8'h14, 1'b1, 1'b0, 1'b0);
        check("fullpp_count", 32'(bus.count), 32'd4);
        check("fullpp_ovf", 32'(bus.overflow), 32'd0);
        check("fullpp_disp", 32'(bus.outputData), 32'h10);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            check("fullpp_drain", 32'(bus.outputData), 32'(8'h10 + i));
        end

        // Wrap-around: one extra push, then ten push+pop cycles
        step(1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(8'h20 + i), 1'b1, 1'b0, 1'b0);
            check("wrap_count_le2", 32'(bus.count <= 2), 32'd1);
        end
        check("wrap_disp", 32'(bus.outputData), 32'h28);
        check("wrap_head", 32'(bus.outData), 32'h29);
        step(1'b1, 8'h2A, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("wrap_drain", 32'(bus.outputData), 32'h2A);

        // Sticky overflow, clear, set-wins, reset mid-operation
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        end
        check("sticky_set", 32'(bus.overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("sticky_hold", 32'(bus.overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("sticky_clr", 32'(bus.overflow), 32'd0);
        step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        check("set_wins", 32'(bus.overflow), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("pre_rst_count", 32'(bus.count), 32'd3);
        check("pre_rst_disp", 32'(bus.outputData), 32'h40);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("midrst_count", 32'(bus.count), 32'd0);
        check("midrst_valid", 32'(bus.outValid), 32'd0);
        check("midrst_disp", 32'(bus.outputData), 32'h00);
        check("midrst_ovf", 32'(bus.overflow), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
